// File: rtl/sumreq_pkg.sv
// Shared types for the sum_requester block.
//
// Contents:
//   state_e  - requester FSM states (IDLE, ISSUE, WAIT, HOLD)
//
// The operand-pair struct depends on the operand width W, which is a module
// parameter. A package cannot be parameterised, so pair_t is declared inside
// sum_requester, where W is known.
package sumreq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/sumreq_fifo.sv
// Synchronous DEPTH x WIDTH FIFO that buffers operand pairs for sum_requester.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (flushes pointers and count)
//   push      in   write request; ignored while full
//   pop       in   read request; ignored while empty
//   wdata     in   WIDTH  data written on an accepted push
//   rdata     out  WIDTH  current head entry (valid while !empty)
//   not_full  out  registered ready flag; 0 in reset, 1 whenever space remains
//   empty     out  registered empty flag
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// Push and pop in the same cycle leave the occupancy unchanged.
module sumreq_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && not_full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: every variable assigned in a combinational block gets a default at
  // the top of the block, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      not_full <= (count_next != FULL_CNT);
      empty    <= (count_next == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the flushed pointers
  // and count guarantee stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sum_requester.sv
// Initiator side of the start/a/b -> valid/y adder protocol.
//
// Operand pairs arrive on a valid/ready port and are buffered in a FIFO. Each
// pair is issued to the adder as a one-cycle start pulse with a/b; the FSM
// then waits for the adder's valid, captures y and presents it on a
// valid/ready result port. Only one request is outstanding at a time.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_a/in_b operands (W bits)
//   start, a, b           adder request pulse and operands
//   valid, y              adder response
//   res_valid/res_ready   downstream handshake; res_sum captured sum (W bits)
//   err                   sticky protocol error (cleared only by rst)
//
// Optional feature (macro SUMREQ_TIMEOUT_EN): abort a request when the adder
// stays silent for TIMEOUT cycles in WAIT; err is set and the FSM returns to IDLE.
module sum_requester
  import sumreq_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic         valid,
  input  logic [W-1:0] y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         err
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sum_requester: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sum_requester: TIMEOUT must be >= 1");
  end

  state_e state;
  pair_t  in_pair;
  pair_t  head;
  logic   fifo_empty;
  logic   issue;

  assign in_pair = '{a: in_a, b: in_b};

  sumreq_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (issue),
    .wdata    (in_pair),
    .rdata    (head),
    .not_full (in_ready),
    .empty    (fifo_empty)
  );

  // A new request leaves the FIFO when the FSM is idle, or when the current
  // result is being accepted downstream and more work is queued.
  assign issue = !fifo_empty &&
                 ((state == IDLE) || (state == HOLD && res_ready));

`ifdef SUMREQ_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      start     <= 1'b0;
      a         <= '0;
      b         <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      err       <= 1'b0;
`ifdef SUMREQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      start <= 1'b0;

      // Any adder response outside WAIT has no request to belong to.
      if (valid && state != WAIT) err <= 1'b1;

      case (state)
        IDLE: ;  // leaves only through issue below
        ISSUE: begin
          state <= WAIT;
`ifdef SUMREQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (valid) begin
            res_sum   <= y;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
`ifdef SUMREQ_TIMEOUT_EN
          // A valid on the final allowed cycle wins over the abort.
          else if (wait_cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // start is only ever raised on entry to ISSUE and cleared by the default
      // above on the following edge, giving exactly one cycle per request.
      if (issue) begin
        state <= ISSUE;
        start <= 1'b1;
        a     <= head.a;
        b     <= head.b;
      end
    end
  end

endmodule
